// File: rtl/conv_sched_pkg.sv
// Shared types and defaults for the conv loop scheduler: FSM states, coordinate
// record carried through the result delay line, and index-width helper.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_MAP_WIDTH     = 64;
    localparam int DEF_MAP_HEIGHT    = 64;
    localparam int DEF_IN_CH         = 4;
    localparam int DEF_OUT_CH        = 32;
    localparam int DEF_KERNEL        = 3;
    localparam int DEF_PIPE_LATENCY  = 3;

    // Coordinates travel zero-extended to a fixed width so one record type serves every map size.
    localparam int COORD_W = 16;

    function automatic int idx_w(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    localparam int DEF_X_W  = idx_w(DEF_MAP_WIDTH);
    localparam int DEF_Y_W  = idx_w(DEF_MAP_HEIGHT);
    localparam int DEF_CO_W = idx_w(DEF_OUT_CH);
    localparam int DEF_CI_W = idx_w(DEF_IN_CH);
    localparam int DEF_K_W  = idx_w(DEF_KERNEL);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] co;
    } coord_t;

endpackage

// File: rtl/conv_idx_delay.sv
// Fixed-depth valid+coordinate shift register that re-times output coordinates
// to line up with the accumulator result; never stalls.
module conv_idx_delay
    import conv_sched_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LATENCY
) (
    input  logic   clk,
    input  logic   arst_n_in,
    input  logic   push,
    input  coord_t push_coord,
    output logic   out_valid,
    output coord_t out_coord,
    output logic   drained
);

    logic [DEPTH-1:0] valid_d, valid_q;
    coord_t           coord_d [DEPTH];
    coord_t           coord_q [DEPTH];

    always_comb begin
        valid_d[0] = push;
        coord_d[0] = push_coord;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            coord_d[i] = coord_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            valid_q <= '0;
            coord_q <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            coord_q <= coord_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_coord = coord_q[DEPTH-1];

    // Drained means the line is empty once the final stage retires this cycle.
    if (DEPTH > 1) begin : g_multi
        assign drained = ~|valid_q[DEPTH-2:0];
    end else begin : g_single
        assign drained = 1'b1;
    end

endmodule

// File: rtl/conv_loop_scheduler.sv
// Conv loop scheduler: walks y/x/co/ky/kx/ci and issues one MAC step per handshake.
// Optional perf counters are built when CONV_SCHED_PERF_EN is defined.
module conv_loop_scheduler
    import conv_sched_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = DEF_MAP_WIDTH,
    parameter int FEATURE_MAP_HEIGHT = DEF_MAP_HEIGHT,
    parameter int INPUT_NB_CHANNELS  = DEF_IN_CH,
    parameter int OUTPUT_NB_CHANNELS = DEF_OUT_CH,
    parameter int KERNEL_SIZE        = DEF_KERNEL,
    parameter int PIPE_LATENCY       = DEF_PIPE_LATENCY,
    localparam int XW  = idx_w(FEATURE_MAP_WIDTH),
    localparam int YW  = idx_w(FEATURE_MAP_HEIGHT),
    localparam int COW = idx_w(OUTPUT_NB_CHANNELS),
    localparam int CIW = idx_w(INPUT_NB_CHANNELS),
    localparam int KW  = idx_w(KERNEL_SIZE)
) (
    input  logic           clk,
    input  logic           arst_n_in,
    input  logic           start,
    output logic           running,
    output logic           done,
    output logic           step_valid,
    input  logic           step_ready,
    output logic [XW-1:0]  step_x,
    output logic [YW-1:0]  step_y,
    output logic [COW-1:0] step_co,
    output logic [CIW-1:0] step_ci,
    output logic [KW-1:0]  step_kx,
    output logic [KW-1:0]  step_ky,
    output logic           step_pad,
    output logic           step_first,
    output logic           step_last,
    output logic           output_valid,
    output logic [XW-1:0]  output_x,
    output logic [YW-1:0]  output_y,
    output logic [COW-1:0] output_ch
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]    perf_cycles,
    output logic [31:0]    perf_stalls
`endif
);

    localparam int HALF = (KERNEL_SIZE - 1) / 2;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [COW-1:0] co_q, co_d;
    logic [CIW-1:0] ci_q, ci_d;
    logic [KW-1:0]  kx_q, kx_d;
    logic [KW-1:0]  ky_q, ky_d;
    logic           ci_max, kx_max, ky_max, co_max, x_max, y_max, all_max;
    logic           accept, start_accept, push, line_drained;
    logic signed [31:0] ix, iy;
    coord_t         push_coord, out_coord;

    // Handshake: a step transfers on a cycle with step_valid && step_ready; while
    // step_ready is low the descriptor holds, and step_valid never drops inside RUN.
    assign accept       = (state_q == RUN) && step_ready;
    assign start_accept = (state_q == IDLE) && start;
    assign push         = accept && step_last;

    assign ci_max  = (ci_q == CIW'(INPUT_NB_CHANNELS - 1));
    assign kx_max  = (kx_q == KW'(KERNEL_SIZE - 1));
    assign ky_max  = (ky_q == KW'(KERNEL_SIZE - 1));
    assign co_max  = (co_q == COW'(OUTPUT_NB_CHANNELS - 1));
    assign x_max   = (x_q == XW'(FEATURE_MAP_WIDTH - 1));
    assign y_max   = (y_q == YW'(FEATURE_MAP_HEIGHT - 1));
    assign all_max = ci_max && kx_max && ky_max && co_max && x_max && y_max;

    always_ff @(posedge clk) begin
        if (!arst_n_in) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && all_max) state_d = DRAIN;
            DRAIN:   if (line_drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done coincides with the final output_valid of the layer.
    always_comb begin
        running    = (state_q != IDLE);
        step_valid = (state_q == RUN);
        done       = (state_q == DRAIN) && line_drained;
    end

    // Innermost-first odometer: ci, kx, ky, co, x, y.
    always_comb begin
        x_d = x_q; y_d = y_q; co_d = co_q; ci_d = ci_q; kx_d = kx_q; ky_d = ky_q;
        if (start_accept) begin
            x_d = '0; y_d = '0; co_d = '0; ci_d = '0; kx_d = '0; ky_d = '0;
        end else if (accept) begin
            ci_d = ci_max ? '0 : ci_q + 1'b1;
            if (ci_max) kx_d = kx_max ? '0 : kx_q + 1'b1;
            if (ci_max && kx_max) ky_d = ky_max ? '0 : ky_q + 1'b1;
            if (ci_max && kx_max && ky_max) co_d = co_max ? '0 : co_q + 1'b1;
            if (ci_max && kx_max && ky_max && co_max) x_d = x_max ? '0 : x_q + 1'b1;
            if (ci_max && kx_max && ky_max && co_max && x_max) y_d = y_max ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            x_q <= '0; y_q <= '0; co_q <= '0; ci_q <= '0; kx_q <= '0; ky_q <= '0;
        end else begin
            x_q <= x_d; y_q <= y_d; co_q <= co_d; ci_q <= ci_d; kx_q <= kx_d; ky_q <= ky_d;
        end
    end

    always_comb begin
        ix         = signed'(32'(x_q)) + signed'(32'(kx_q)) - HALF;
        iy         = signed'(32'(y_q)) + signed'(32'(ky_q)) - HALF;
        step_pad   = step_valid && ((ix < 0) || (ix >= FEATURE_MAP_WIDTH) ||
                                    (iy < 0) || (iy >= FEATURE_MAP_HEIGHT));
        step_first = step_valid && (ci_q == '0) && (kx_q == '0) && (ky_q == '0);
        step_last  = step_valid && ci_max && kx_max && ky_max;
    end

    assign step_x  = x_q;
    assign step_y  = y_q;
    assign step_co = co_q;
    assign step_ci = ci_q;
    assign step_kx = kx_q;
    assign step_ky = ky_q;

    assign push_coord = '{x: COORD_W'(x_q), y: COORD_W'(y_q), co: COORD_W'(co_q)};

    conv_idx_delay #(
        .DEPTH (PIPE_LATENCY)
    ) u_idx_delay (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .push       (push),
        .push_coord (push_coord),
        .out_valid  (output_valid),
        .out_coord  (out_coord),
        .drained    (line_drained)
    );

    assign output_x  = out_coord.x[XW-1:0];
    assign output_y  = out_coord.y[YW-1:0];
    assign output_ch = out_coord.co[COW-1:0];

    logic unused_coord_bits;
    assign unused_coord_bits = ^{out_coord.x[COORD_W-1:XW], out_coord.y[COORD_W-1:YW],
                                 out_coord.co[COORD_W-1:COW]};

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (start_accept) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (running && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 1'b1;
            if ((state_q == RUN) && !step_ready && (perf_stalls_q != '1))
                perf_stalls_d = perf_stalls_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
